cache_fill_ctrl: RTL and testbench

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_ctrl_pkg.sv | 25 ++
 rtl/fill_counter.sv | 45 ++++
 rtl/cache_fill_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared definitions for the cache fill controller:
//   - state_e      : controller states (IDLE, WRITE, FILL, DONE)
//   - BLOCK_WORDS  : default number of 16-bit words per cache block
//   - SEL_I/SEL_D  : fill_sel encoding for the I-cache and D-cache arrays
//   - BLOCK_MASK   : clears the byte offset inside a 16-byte block
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

  localparam int BLOCK_WORDS = 8;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  localparam logic [15:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fill_counter.sv
// ---------------------------------------------------------------------------
// fill_counter
// Saturating up-counter with synchronous clear and count enable. Used for
// both the read-issue and the read-receive word counts of a block fill.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous clear (count -> 0), wins over en
//   en   : increment by one unless already at MAX
//   cnt  : current count
// ---------------------------------------------------------------------------
module fill_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_fill_ctrl
// Shared memory-port controller for an I-cache and a D-cache. It arbitrates
// between D misses, D write-through stores and I misses (in that priority),
// performs single-cycle stores, and fills a whole block by issuing one read
// per cycle while counting returned words independently of memory latency.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_miss, i_miss_addr      : I-cache miss request (held until i_done)
//   d_miss, d_miss_addr      : D-cache miss request (held until d_done)
//   d_wr_req, d_wr_addr,
//   d_wr_data                : D-side store request (held until d_wr_ack)
//   mem_rdata, mem_rvalid    : memory read return
//   mem_en, mem_wr,
//   mem_addr, mem_wdata      : memory access port
//   fill_we, fill_sel,
//   fill_word, fill_data     : cache data-array write (fill_sel 0=I, 1=D)
//   tag_we                   : tag/valid write for the array chosen by fill_sel
//   i_done, d_done, d_wr_ack : one-cycle completion pulses
// ---------------------------------------------------------------------------
module cache_fill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int BLOCK_WORDS = cache_ctrl_pkg::BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        tag_we,
  output logic        i_done,
  output logic        d_done,
  output logic        d_wr_ack
);

  // One extra counter bit so "all words done" is distinguishable from word 0.
  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  state_e      state_q, state_d;
  logic [15:0] base_q,  base_d;
  logic        sel_q,   sel_d;

  logic             cnt_clr;
  logic             issue_en;
  logic             recv_en;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;

  fill_counter #(
    .W   (CNT_W),
    .MAX (BLOCK_WORDS)
  ) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt)
  );

  fill_counter #(
    .W   (CNT_W),
    .MAX (BLOCK_WORDS)
  ) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv_en),
    .cnt (recv_cnt)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    sel_d     = sel_q;
    cnt_clr   = 1'b0;
    issue_en  = 1'b0;
    recv_en   = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we   = 1'b0;
    fill_word = '0;
    fill_data = '0;
    tag_we    = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    d_wr_ack  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Fixed priority: D miss, then D store, then I miss.
        if (d_miss) begin
          base_d  = d_miss_addr & BLOCK_MASK;
          sel_d   = SEL_D;
          cnt_clr = 1'b1;
          state_d = ST_FILL;
        end else if (d_wr_req) begin
          state_d = ST_WRITE;
        end else if (i_miss) begin
          base_d  = i_miss_addr & BLOCK_MASK;
          sel_d   = SEL_I;
          cnt_clr = 1'b1;
          state_d = ST_FILL;
        end
      end

      ST_WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_FILL: begin
        // Issue side: one read per cycle until every word has been requested.
        if (issue_cnt < FULL_CNT) begin
          mem_en   = 1'b1;
          mem_addr = base_q + 16'({issue_cnt, 1'b0});
          issue_en = 1'b1;
        end
        // Receive side: purely counted, so any memory latency works and an
        // issue and a return in the same cycle are both taken.
        if (mem_rvalid && (recv_cnt < FULL_CNT)) begin
          fill_we   = 1'b1;
          fill_word = 3'(recv_cnt);
          fill_data = mem_rdata;
          recv_en   = 1'b1;
          if (recv_cnt == LAST_WORD) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        tag_we = 1'b1;
        if (sel_q == SEL_D) begin
          d_done = 1'b1;
        end else begin
          i_done = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      sel_q   <= SEL_I;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      sel_q   <= sel_d;
    end
  end

  assign fill_sel = sel_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_ctrl
// Directed bench for cache_fill_ctrl. A fixed-latency memory and simple
// requesters (which drop their request on the matching completion pulse)
// surround the DUT. A transaction-level model predicts every output from the
// cycle offset since a request was accepted and the count of returned words.
// Outputs are logged per cycle so that hand-computed literals can be checked
// at the end of each scenario.
// ---------------------------------------------------------------------------
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        fill_we;
  logic        fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        tag_we;
  logic        i_done;
  logic        d_done;
  logic        d_wr_ack;

  cache_fill_ctrl #(.BLOCK_WORDS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .fill_we     (fill_we),
    .fill_sel    (fill_sel),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .tag_we      (tag_we),
    .i_done      (i_done),
    .d_done      (d_done),
    .d_wr_ack    (d_wr_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 4;
  bit stray_next = 1'b0;

  // Memory: reads return (addr ^ 16'h5A5A) exactly lat cycles after issue.
  typedef struct {
    int          due;
    logic [15:0] addr;
  } rd_t;
  rd_t mq[$];

  // Model: 0 idle, 1 store pending, 2 fill in progress, 3 completion expected.
  int          m_job = 0;
  int          m_acc = 0;
  logic [15:0] m_base = '0;
  logic        m_sel = 1'b0;
  int          m_rv = 0;
  logic [15:0] m_waddr = '0;
  logic [15:0] m_wdata = '0;

  localparam int LOGN = 1024;
  logic        o_en   [LOGN];
  logic        o_wr   [LOGN];
  logic [15:0] o_addr [LOGN];
  logic [15:0] o_wdat [LOGN];
  logic        o_we   [LOGN];
  logic [2:0]  o_word [LOGN];
  logic [15:0] o_data [LOGN];
  logic        o_sel  [LOGN];
  logic        o_tag  [LOGN];
  logic        o_idn  [LOGN];
  logic        o_ddn  [LOGN];
  logic        o_ack  [LOGN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int cnt_we(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (o_we[t]) n++;
    return n;
  endfunction

  function automatic int cnt_fin(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (o_tag[t] || o_idn[t] || o_ddn[t]) n++;
    return n;
  endfunction

  // Compare every output against the model for the current cycle.
  task automatic model_check();
    int k;
    case (m_job)
      0: begin
        chk("idle_mem_en", 32'(mem_en), 32'(1'b0));
        chk("idle_fill_we", 32'(fill_we), 32'(1'b0));
        chk("idle_tag_we", 32'(tag_we), 32'(1'b0));
        chk("idle_done", 32'({i_done, d_done, d_wr_ack}), 32'(3'b000));
        if (d_miss) begin
          m_job = 2; m_acc = cyc; m_base = d_miss_addr & 16'hFFF0; m_sel = 1'b1; m_rv = 0;
        end else if (d_wr_req) begin
          m_job = 1; m_acc = cyc; m_waddr = d_wr_addr; m_wdata = d_wr_data;
        end else if (i_miss) begin
          m_job = 2; m_acc = cyc; m_base = i_miss_addr & 16'hFFF0; m_sel = 1'b0; m_rv = 0;
        end
      end
      1: begin
        chk("wr_mem_en", 32'(mem_en), 32'(1'b1));
        chk("wr_mem_wr", 32'(mem_wr), 32'(1'b1));
        chk("wr_addr", 32'(mem_addr), 32'(m_waddr));
        chk("wr_data", 32'(mem_wdata), 32'(m_wdata));
        chk("wr_ack", 32'(d_wr_ack), 32'(1'b1));
        chk("wr_fill_we", 32'(fill_we), 32'(1'b0));
        m_job = 0;
      end
      2: begin
        k = cyc - m_acc;
        chk("fill_mem_en", 32'(mem_en), 32'(k <= 8));
        if (k <= 8) begin
          chk("fill_mem_wr", 32'(mem_wr), 32'(1'b0));
          chk("fill_addr", 32'(mem_addr), 32'(16'(m_base + 16'(2 * (k - 1)))));
        end
        chk("fill_we", 32'(fill_we), 32'(mem_rvalid && (m_rv < 8)));
        if (mem_rvalid && (m_rv < 8)) begin
          chk("fill_word", 32'(fill_word), 32'(m_rv));
          chk("fill_data", 32'(fill_data), 32'(mem_rdata));
          chk("fill_sel", 32'(fill_sel), 32'(m_sel));
          m_rv++;
          if (m_rv == 8) m_job = 3;
        end
        chk("fill_fin", 32'({tag_we, i_done, d_done, d_wr_ack}), 32'(4'b0000));
      end
      default: begin
        chk("done_tag_we", 32'(tag_we), 32'(1'b1));
        chk("done_i", 32'(i_done), 32'(m_sel == 1'b0));
        chk("done_d", 32'(d_done), 32'(m_sel == 1'b1));
        chk("done_sel", 32'(fill_sel), 32'(m_sel));
        chk("done_quiet", 32'({fill_we, mem_en}), 32'(2'b00));
        m_job = 0;
      end
    endcase
  endtask

  // One clock cycle: sample mid-cycle, then advance past the next edge and
  // drive the requesters and the memory for the new cycle.
  task automatic cycle();
    logic r, gi, gd, ga;
    #4;
    o_en[cyc] = mem_en;     o_wr[cyc] = mem_wr;
    o_addr[cyc] = mem_addr; o_wdat[cyc] = mem_wdata;
    o_we[cyc] = fill_we;    o_word[cyc] = fill_word;
    o_data[cyc] = fill_data; o_sel[cyc] = fill_sel;
    o_tag[cyc] = tag_we;    o_idn[cyc] = i_done;
    o_ddn[cyc] = d_done;    o_ack[cyc] = d_wr_ack;
    r = rst;
    if (!r) model_check();
    if (mem_en && !mem_wr) mq.push_back('{cyc + lat, mem_addr});
    gi = i_done; gd = d_done; ga = d_wr_ack;
    @(posedge clk);
    #1;
    cyc++;
    if (r) m_job = 0;
    if (gi) i_miss = 1'b0;
    if (gd) d_miss = 1'b0;
    if (ga) d_wr_req = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 16'hDEAD;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mq[0].addr ^ 16'h5A5A;
      void'(mq.pop_front());
    end
    if (stray_next) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h7777;
      stray_next = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((i_miss || d_miss || d_wr_req || m_job != 0 || mq.size() != 0) && n < 100);
    if (i_miss || d_miss || d_wr_req || m_job != 0 || mq.size() != 0) begin
      chk({nm, "_timeout"}, 32'(n), 32'(0));
    end
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    i_miss = 1'b0; i_miss_addr = '0;
    d_miss = 1'b0; d_miss_addr = '0;
    d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) cycle();
    rst = 1'b0;
    t0 = cyc;
    repeat (2) cycle();
    chk("rst_mem_en", 32'(o_en[t0]), 32'(1'b0));
    chk("rst_sel", 32'(o_sel[t0]), 32'(1'b0));
    chk("rst_fin", 32'({o_tag[t0], o_idn[t0], o_ddn[t0], o_ack[t0], o_we[t0]}), 32'(5'b0));

    // Basic I miss, 4-cycle memory.
    i_miss = 1'b1; i_miss_addr = 16'h1236; t0 = cyc;
    wait_idle("imiss");
    chk("i_first_addr", 32'(o_addr[t0 + 1]), 32'(16'h1230));
    chk("i_last_addr", 32'(o_addr[t0 + 8]), 32'(16'h123E));
    chk("i_issue_stop", 32'(o_en[t0 + 9]), 32'(1'b0));
    chk("i_we_before", 32'(o_we[t0 + 4]), 32'(1'b0));
    chk("i_we_first", 32'({o_we[t0 + 5], o_word[t0 + 5]}), 32'({1'b1, 3'd0}));
    chk("i_data_first", 32'(o_data[t0 + 5]), 32'(16'h486A));
    chk("i_we_last", 32'({o_we[t0 + 12], o_word[t0 + 12]}), 32'({1'b1, 3'd7}));
    chk("i_data_last", 32'(o_data[t0 + 12]), 32'(16'h4864));
    chk("i_done_cyc", 32'({o_tag[t0 + 13], o_idn[t0 + 13], o_sel[t0 + 13]}), 32'(3'b110));

    // Simultaneous I and D misses: D first.
    i_miss = 1'b1; i_miss_addr = 16'h2000;
    d_miss = 1'b1; d_miss_addr = 16'h3008; t0 = cyc;
    wait_idle("both");
    chk("both_d_addr", 32'(o_addr[t0 + 1]), 32'(16'h3000));
    chk("both_d_done", 32'({o_ddn[t0 + 13], o_idn[t0 + 13]}), 32'(2'b10));
    chk("both_i_addr", 32'(o_addr[t0 + 15]), 32'(16'h2000));
    chk("both_i_done", 32'(o_idn[t0 + 27]), 32'(1'b1));

    // Store with simultaneous I miss.
    d_wr_req = 1'b1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
    i_miss = 1'b1; i_miss_addr = 16'h4444; t0 = cyc;
    wait_idle("store");
    chk("st_write", 32'({o_en[t0 + 1], o_wr[t0 + 1], o_ack[t0 + 1]}), 32'(3'b111));
    chk("st_addr", 32'(o_addr[t0 + 1]), 32'(16'h0040));
    chk("st_data", 32'(o_wdat[t0 + 1]), 32'(16'hBEEF));
    chk("st_i_issue", 32'({o_en[t0 + 3], o_addr[t0 + 3]}), 32'({1'b1, 16'h4440}));
    chk("st_i_done", 32'(o_idn[t0 + 15]), 32'(1'b1));

    // 1-cycle memory latency.
    lat = 1;
    i_miss = 1'b1; i_miss_addr = 16'h00FF; t0 = cyc;
    wait_idle("lat1");
    chk("l1_we_count", 32'(cnt_we(t0, t0 + 10)), 32'(8));
    chk("l1_we_span", 32'({o_we[t0 + 2], o_we[t0 + 9]}), 32'(2'b11));
    chk("l1_done", 32'(o_idn[t0 + 10]), 32'(1'b1));
    lat = 4;

    // Reset after the third returned word.
    i_miss = 1'b1; i_miss_addr = 16'h5550; t0 = cyc;
    repeat (8) cycle();
    rst = 1'b1; i_miss = 1'b0;
    cycle();
    rst = 1'b0;
    wait_idle("rstmid");
    chk("rm_we_before", 32'(cnt_we(t0, t0 + 7)), 32'(3));
    chk("rm_after_en", 32'(o_en[t0 + 9]), 32'(1'b0));
    chk("rm_after_we", 32'(cnt_we(t0 + 9, t0 + 20)), 32'(0));
    chk("rm_no_fin", 32'(cnt_fin(t0, t0 + 20)), 32'(0));

    // Stray rvalid in IDLE, then a D miss.
    stray_next = 1'b1;
    cycle();
    t0 = cyc;
    cycle();
    chk("stray_we", 32'(o_we[t0]), 32'(1'b0));
    d_miss = 1'b1; d_miss_addr = 16'h8A5C; t0 = cyc;
    wait_idle("stray");
    chk("sd_addr", 32'(o_addr[t0 + 1]), 32'(16'h8A50));
    chk("sd_we_count", 32'(cnt_we(t0, t0 + 13)), 32'(8));
    chk("sd_done", 32'({o_ddn[t0 + 13], o_sel[t0 + 13]}), 32'(2'b11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
